// File: rtl/basket_pkg.sv
// basket_pkg: shared types and constants for the basket controller.
//   ID_W, QTY_W       : product ID and quantity widths
//   QTY_MAX           : per-entry quantity ceiling
//   MAX_ITEMS_DEFAULT : default basket capacity in entries
//   state_t           : controller FSM states
//   entry_t           : one basket record (id, qty)
//   sat_add()         : quantity add that clips at QTY_MAX and reports the clip
package basket_pkg;

    localparam int unsigned ID_W              = 4;
    localparam int unsigned QTY_W             = 4;
    localparam int unsigned QTY_MAX           = 15;
    localparam int unsigned MAX_ITEMS_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEARCH  = 2'd1,
        COMPACT = 2'd2
    } state_t;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [QTY_W-1:0] qty;
    } entry_t;

    // Returns {clipped, result}; result saturates at QTY_MAX.
    function automatic logic [QTY_W:0] sat_add(input logic [QTY_W-1:0] a,
                                               input logic [QTY_W-1:0] b);
        logic [QTY_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > (QTY_W + 1)'(QTY_MAX)) begin
            sat_add = {1'b1, QTY_W'(QTY_MAX)};
        end else begin
            sat_add = {1'b0, sum[QTY_W-1:0]};
        end
    endfunction

endpackage

// File: rtl/basket_controller.sv
// basket_controller: ordered basket of (product ID, quantity) entries.
//   CLOCK_50, RESET_N          : clock, async active-low reset
//   Enable/ProductID/Quantity  : add pulse; merges into a matching entry or appends
//   Remove/RemoveIndex         : remove pulse; later entries shift down one slot
//   Clear                      : empty the basket, accepted in any state
//   ReadIndex -> Read*         : combinational read port, zero when out of range
//   BasketProductNum           : number of occupied entries
//   TotalQuantity              : sum of all entry quantities
//   Busy                       : add search or remove compaction in progress
//   ErrorPulse                 : one-cycle flag for rejected or saturated commands
module basket_controller
    import basket_pkg::*;
#(
    parameter int unsigned MAX_ITEMS = MAX_ITEMS_DEFAULT
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             Enable,
    input  logic [ID_W-1:0]  ProductID,
    input  logic [QTY_W-1:0] ProductQuantity,
    input  logic             Remove,
    input  logic [3:0]       RemoveIndex,
    input  logic             Clear,
    input  logic [3:0]       ReadIndex,
    output logic [ID_W-1:0]  ReadProductID,
    output logic [QTY_W-1:0] ReadQuantity,
    output logic             ReadValid,
    output logic [3:0]       BasketProductNum,
    output logic [7:0]       TotalQuantity,
    output logic             Busy,
    output logic             ErrorPulse
);

    localparam logic [3:0] CAP = 4'(MAX_ITEMS);

    state_t           state_q, state_d;
    logic [3:0]       idx_q, idx_d;
    entry_t           cmd_q, cmd_d;
    logic [3:0]       count_q, count_d;
    logic [7:0]       total_q, total_d;
    logic             err_q, err_d;
    logic [ID_W-1:0]  ids_q [MAX_ITEMS];
    logic [ID_W-1:0]  ids_d [MAX_ITEMS];
    logic [QTY_W-1:0] qty_q [MAX_ITEMS];
    logic [QTY_W-1:0] qty_d [MAX_ITEMS];

    logic [3:0]       idx_nxt, last_idx;
    logic [ID_W-1:0]  cur_id, nxt_id, rd_id;
    logic [QTY_W-1:0] cur_qty, nxt_qty, rm_qty, rd_qty;
    logic [QTY_W:0]   merged;

    assign idx_nxt  = idx_q + 4'd1;
    assign last_idx = count_q - 4'd1;
    assign merged   = sat_add(cur_qty, cmd_q.qty);

    // Entry lookups as explicit compare-select so 4-bit indices never address
    // beyond the array when MAX_ITEMS is not a power of two.
    always_comb begin
        cur_id  = '0;
        cur_qty = '0;
        nxt_id  = '0;
        nxt_qty = '0;
        rm_qty  = '0;
        rd_id   = '0;
        rd_qty  = '0;
        for (int i = 0; i < int'(MAX_ITEMS); i++) begin
            if (idx_q == 4'(i)) begin
                cur_id  = ids_q[i];
                cur_qty = qty_q[i];
            end
            if (idx_nxt == 4'(i)) begin
                nxt_id  = ids_q[i];
                nxt_qty = qty_q[i];
            end
            if (RemoveIndex == 4'(i)) begin
                rm_qty = qty_q[i];
            end
            if (ReadIndex == 4'(i)) begin
                rd_id  = ids_q[i];
                rd_qty = qty_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cmd_d   = cmd_q;
        count_d = count_q;
        total_d = total_q;
        err_d   = 1'b0;
        ids_d   = ids_q;
        qty_d   = qty_q;

        if (Clear) begin
            state_d = IDLE;
            idx_d   = '0;
            count_d = '0;
            total_d = '0;
            for (int i = 0; i < int'(MAX_ITEMS); i++) begin
                ids_d[i] = '0;
                qty_d[i] = '0;
            end
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (Remove) begin
                        if (RemoveIndex >= count_q) begin
                            err_d = 1'b1;
                        end else begin
                            // Total drops at acceptance; compaction only moves data.
                            total_d = total_q - 8'(rm_qty);
                            idx_d   = RemoveIndex;
                            state_d = COMPACT;
                        end
                    end else if (Enable && (ProductQuantity != '0)) begin
                        cmd_d   = '{id: ProductID, qty: ProductQuantity};
                        idx_d   = '0;
                        state_d = SEARCH;
                    end
                end

                SEARCH: begin
                    err_d = Enable | Remove;
                    if (idx_q == count_q) begin
                        state_d = IDLE;
                        if (count_q == CAP) begin
                            err_d = 1'b1;
                        end else begin
                            for (int i = 0; i < int'(MAX_ITEMS); i++) begin
                                if (count_q == 4'(i)) begin
                                    ids_d[i] = cmd_q.id;
                                    qty_d[i] = cmd_q.qty;
                                end
                            end
                            count_d = count_q + 4'd1;
                            total_d = total_q + 8'(cmd_q.qty);
                        end
                    end else if (cur_id == cmd_q.id) begin
                        state_d = IDLE;
                        for (int i = 0; i < int'(MAX_ITEMS); i++) begin
                            if (idx_q == 4'(i)) begin
                                qty_d[i] = merged[QTY_W-1:0];
                            end
                        end
                        // Only the increment actually stored counts toward the total.
                        total_d = total_q + 8'(merged[QTY_W-1:0]) - 8'(cur_qty);
                        err_d   = err_d | merged[QTY_W];
                    end else begin
                        idx_d = idx_nxt;
                    end
                end

                COMPACT: begin
                    err_d = Enable | Remove;
                    if (idx_q < last_idx) begin
                        for (int i = 0; i < int'(MAX_ITEMS); i++) begin
                            if (idx_q == 4'(i)) begin
                                ids_d[i] = nxt_id;
                                qty_d[i] = nxt_qty;
                            end
                        end
                        idx_d = idx_nxt;
                    end else begin
                        for (int i = 0; i < int'(MAX_ITEMS); i++) begin
                            if (last_idx == 4'(i)) begin
                                ids_d[i] = '0;
                                qty_d[i] = '0;
                            end
                        end
                        count_d = last_idx;
                        state_d = IDLE;
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cmd_q   <= '0;
            count_q <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < int'(MAX_ITEMS); i++) begin
                ids_q[i] <= '0;
                qty_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            count_q <= count_d;
            total_q <= total_d;
            err_q   <= err_d;
            ids_q   <= ids_d;
            qty_q   <= qty_d;
        end
    end

    assign ReadValid        = (ReadIndex < count_q);
    assign ReadProductID    = ReadValid ? rd_id : '0;
    assign ReadQuantity     = ReadValid ? rd_qty : '0;
    assign BasketProductNum = count_q;
    assign TotalQuantity    = total_q;
    assign Busy             = (state_q != IDLE);
    assign ErrorPulse       = err_q;

endmodule

// File: tb/tb_basket_controller.sv
`timescale 1ns/1ps
module tb_basket_controller;

    localparam int MAX    = 8;
    localparam int OP_ADD = 0;
    localparam int OP_REM = 1;
    localparam int OP_CLR = 2;

    logic       CLOCK_50 = 1'b0;
    logic       RESET_N = 1'b0;
    logic       Enable = 1'b0;
    logic       Remove = 1'b0;
    logic       Clear = 1'b0;
    logic [3:0] ProductID = '0;
    logic [3:0] ProductQuantity = '0;
    logic [3:0] RemoveIndex = '0;
    logic [3:0] ReadIndex = '0;
    logic [3:0] ReadProductID;
    logic [3:0] ReadQuantity;
    logic       ReadValid;
    logic [3:0] BasketProductNum;
    logic [7:0] TotalQuantity;
    logic       Busy;
    logic       ErrorPulse;

    basket_controller #(.MAX_ITEMS(MAX)) dut (
        .CLOCK_50        (CLOCK_50),
        .RESET_N         (RESET_N),
        .Enable          (Enable),
        .ProductID       (ProductID),
        .ProductQuantity (ProductQuantity),
        .Remove          (Remove),
        .RemoveIndex     (RemoveIndex),
        .Clear           (Clear),
        .ReadIndex       (ReadIndex),
        .ReadProductID   (ReadProductID),
        .ReadQuantity    (ReadQuantity),
        .ReadValid       (ReadValid),
        .BasketProductNum(BasketProductNum),
        .TotalQuantity   (TotalQuantity),
        .Busy            (Busy),
        .ErrorPulse      (ErrorPulse)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference basket: parallel queues in insertion order.
    int m_id[$];
    int m_qty[$];

    typedef struct {
        int op; int id; int qty; int idx;
        int lat; int err; int cnt; int tot;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int model_total();
        int s = 0;
        foreach (m_qty[i]) s += m_qty[i];
        return s;
    endfunction

    // Applies one command to the reference basket; returns expected busy length and error.
    task automatic model_op(input int op, input int id, input int qty, input int idx,
                            output int lat, output int err);
        int found;
        int s;
        lat = 0;
        err = 0;
        if (op == OP_ADD) begin
            if (qty != 0) begin
                found = -1;
                for (int i = 0; i < m_id.size(); i++) begin
                    if (found < 0 && m_id[i] == id) found = i;
                end
                if (found >= 0) begin
                    s = m_qty[found] + qty;
                    err = (s > 15) ? 1 : 0;
                    m_qty[found] = (s > 15) ? 15 : s;
                    lat = found + 1;
                end else begin
                    lat = m_id.size() + 1;
                    if (m_id.size() == MAX) begin
                        err = 1;
                    end else begin
                        m_id.push_back(id);
                        m_qty.push_back(qty);
                    end
                end
            end
        end else if (op == OP_REM) begin
            if (idx >= m_id.size()) begin
                err = 1;
            end else begin
                lat = m_id.size() - idx;
                m_id.delete(idx);
                m_qty.delete(idx);
            end
        end else begin
            m_id.delete();
            m_qty.delete();
        end
    endtask

    task automatic check_basket(input string tag);
        int ev, eid, eq;
        check({tag, "_count"}, int'(BasketProductNum), m_id.size());
        check({tag, "_total"}, int'(TotalQuantity), model_total());
        for (int r = 0; r < 16; r++) begin
            ReadIndex = 4'(r);
            #0.25;
            ev = 0; eid = 0; eq = 0;
            if (r < m_id.size()) begin
                ev = 1; eid = m_id[r]; eq = m_qty[r];
            end
            check($sformatf("%s_rd%0d_valid", tag, r), int'(ReadValid), ev);
            check($sformatf("%s_rd%0d_id", tag, r), int'(ReadProductID), eid);
            check($sformatf("%s_rd%0d_qty", tag, r), int'(ReadQuantity), eq);
        end
        ReadIndex = '0;
    endtask

    // Called just after a falling edge; pulses one command and measures busy length.
    task automatic drive_op(input int op, input int id, input int qty, input int idx,
                            output int lat, output int err, output int err2, output int snap);
        if (op == OP_ADD) begin
            Enable = 1'b1; ProductID = 4'(id); ProductQuantity = 4'(qty);
        end else if (op == OP_REM) begin
            Remove = 1'b1; RemoveIndex = 4'(idx);
        end else begin
            Clear = 1'b1;
        end
        @(negedge CLOCK_50);
        Enable = 1'b0; Remove = 1'b0; Clear = 1'b0;
        snap = int'(TotalQuantity);
        lat = 0;
        while (Busy && lat < 4 * MAX) begin
            lat++;
            @(negedge CLOCK_50);
        end
        err = int'(ErrorPulse);
        @(negedge CLOCK_50);
        err2 = int'(ErrorPulse);
    endtask

    task automatic run_op(input string tag, input int op, input int id, input int qty,
                          input int idx, input bit from_model, input int e_lat,
                          input int e_err, input int e_cnt, input int e_tot);
        int old_tot, m_lat, m_err, exp_snap;
        int lat, err, err2, snap;
        old_tot = model_total();
        model_op(op, id, qty, idx, m_lat, m_err);
        exp_snap = (op == OP_ADD) ? old_tot : model_total();
        if (from_model) begin
            e_lat = m_lat; e_err = m_err; e_cnt = m_id.size(); e_tot = model_total();
        end
        drive_op(op, id, qty, idx, lat, err, err2, snap);
        check({tag, "_latency"}, lat, e_lat);
        check({tag, "_err"}, err, e_err);
        check({tag, "_err_one_cycle"}, err2, 0);
        check({tag, "_total_at_accept"}, snap, exp_snap);
        check({tag, "_cnt"}, int'(BasketProductNum), e_cnt);
        check({tag, "_tot"}, int'(TotalQuantity), e_tot);
        check_basket(tag);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy && n < 64) begin
            n++;
            @(negedge CLOCK_50);
        end
        check({tag, "_idle_timeout"}, int'(Busy), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int op, id, qty, idx, r;

        // Reset state, checked while held and after release.
        #5;
        check("rst_busy", int'(Busy), 0);
        check("rst_err", int'(ErrorPulse), 0);
        check("rst_count", int'(BasketProductNum), 0);
        check("rst_total", int'(TotalQuantity), 0);
        check("rst_valid", int'(ReadValid), 0);
        check("rst_rd_id", int'(ReadProductID), 0);
        check("rst_rd_qty", int'(ReadQuantity), 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        check_basket("post_rst");

        // Directed table: {op, id, qty, idx, latency, err, count, total}
        vecs.push_back('{OP_ADD, 5, 2, 0, 1, 0, 1, 2});
        vecs.push_back('{OP_ADD, 3, 4, 0, 2, 0, 2, 6});
        vecs.push_back('{OP_ADD, 7, 1, 0, 3, 0, 3, 7});
        vecs.push_back('{OP_ADD, 3, 4, 0, 2, 0, 3, 11});
        vecs.push_back('{OP_ADD, 3, 4, 0, 2, 0, 3, 15});
        vecs.push_back('{OP_ADD, 3, 4, 0, 2, 1, 3, 18});
        vecs.push_back('{OP_ADD, 3, 1, 0, 2, 1, 3, 18});
        vecs.push_back('{OP_ADD, 9, 0, 0, 0, 0, 3, 18});
        vecs.push_back('{OP_REM, 0, 0, 3, 0, 1, 3, 18});
        vecs.push_back('{OP_REM, 0, 0, 0, 3, 0, 2, 16});
        vecs.push_back('{OP_ADD, 7, 4, 0, 2, 0, 2, 20});
        vecs.push_back('{OP_CLR, 0, 0, 0, 0, 0, 0, 0});
        for (int k = 1; k <= MAX; k++) vecs.push_back('{OP_ADD, k, 1, 0, k, 0, k, k});
        vecs.push_back('{OP_ADD, 9, 1, 0, 9, 1, 8, 8});
        vecs.push_back('{OP_ADD, 8, 2, 0, 8, 0, 8, 10});
        vecs.push_back('{OP_REM, 0, 0, 1, 7, 0, 7, 9});
        vecs.push_back('{OP_REM, 0, 0, 7, 0, 1, 7, 9});
        vecs.push_back('{OP_REM, 0, 0, 6, 1, 0, 6, 6});
        foreach (vecs[v]) begin
            run_op($sformatf("vec%0d", v), vecs[v].op, vecs[v].id, vecs[v].qty,
                   vecs[v].idx, 1'b0, vecs[v].lat, vecs[v].err, vecs[v].cnt, vecs[v].tot);
        end

        // Second add while busy is dropped with an error; first add still lands.
        Enable = 1'b1; ProductID = 4'd14; ProductQuantity = 4'd3;
        @(negedge CLOCK_50);
        ProductID = 4'd15; ProductQuantity = 4'd1;
        @(negedge CLOCK_50);
        Enable = 1'b0;
        check("drop_add_err", int'(ErrorPulse), 1);
        check("drop_add_busy", int'(Busy), 1);
        wait_idle("drop_add");
        check("drop_add_no_err_at_commit", int'(ErrorPulse), 0);
        m_id.push_back(14);
        m_qty.push_back(3);
        check_basket("drop_add");

        // Second remove while compacting is dropped with an error.
        Remove = 1'b1; RemoveIndex = 4'd0;
        @(negedge CLOCK_50);
        RemoveIndex = 4'd1;
        @(negedge CLOCK_50);
        Remove = 1'b0;
        check("drop_rem_err", int'(ErrorPulse), 1);
        wait_idle("drop_rem");
        m_id.delete(0);
        m_qty.delete(0);
        check_basket("drop_rem");

        // Clear mid-search wins over a simultaneous Enable.
        Enable = 1'b1; ProductID = 4'd13; ProductQuantity = 4'd2;
        @(negedge CLOCK_50);
        Enable = 1'b0;
        check("clr_search_busy", int'(Busy), 1);
        Clear = 1'b1; Enable = 1'b1; ProductID = 4'd2; ProductQuantity = 4'd1;
        @(negedge CLOCK_50);
        Clear = 1'b0; Enable = 1'b0;
        check("clr_search_count", int'(BasketProductNum), 0);
        check("clr_search_total", int'(TotalQuantity), 0);
        check("clr_search_busy_after", int'(Busy), 0);
        check("clr_search_err", int'(ErrorPulse), 0);
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        m_id.delete();
        m_qty.delete();
        check_basket("clr_search");

        // Asynchronous reset during compaction aborts immediately.
        run_op("pre_rst_a", OP_ADD, 4, 2, 0, 1'b1, 0, 0, 0, 0);
        run_op("pre_rst_b", OP_ADD, 6, 3, 0, 1'b1, 0, 0, 0, 0);
        run_op("pre_rst_c", OP_ADD, 10, 4, 0, 1'b1, 0, 0, 0, 0);
        Remove = 1'b1; RemoveIndex = 4'd0;
        @(negedge CLOCK_50);
        Remove = 1'b0;
        check("rst_mid_busy_before", int'(Busy), 1);
        #2 RESET_N = 1'b0;
        #1;
        check("rst_mid_count", int'(BasketProductNum), 0);
        check("rst_mid_total", int'(TotalQuantity), 0);
        check("rst_mid_busy", int'(Busy), 0);
        check("rst_mid_valid", int'(ReadValid), 0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        @(negedge CLOCK_50);
        m_id.delete();
        m_qty.delete();
        check_basket("rst_mid");

        // Randomized commands against the reference basket.
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            id = $urandom_range(0, 11);
            qty = $urandom_range(0, 4);
            idx = $urandom_range(0, 9);
            if (r < 58) op = OP_ADD;
            else if (r < 95) op = OP_REM;
            else op = OP_CLR;
            run_op($sformatf("rnd%0d", n), op, id, qty, idx, 1'b1, 0, 0, 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
